// File: rtl/dl_ant_deint_60m_if.sv
// Bus bundle between the downlink datapath and the antenna de-interleaver.
// The master drives the serial IQ side; the slave returns the parallel antenna word.
interface dl_ant_deint_60m_if;
    logic [31:0]  i_data;
    logic         i_ant8_sel;
    logic         i_fram_hd;
    logic         i_err_clr;
    logic [255:0] o_ant_data;
    logic         o_vld;
    logic         o_fram_hd;
    logic         o_lock;
    logic [15:0]  o_err_cnt;

    modport master (
        output i_data, i_ant8_sel, i_fram_hd, i_err_clr,
        input  o_ant_data, o_vld, o_fram_hd, o_lock, o_err_cnt
    );

    modport slave (
        input  i_data, i_ant8_sel, i_fram_hd, i_err_clr,
        output o_ant_data, o_vld, o_fram_hd, o_lock, o_err_cnt
    );
endinterface

// File: rtl/dl_ant_deint_60m.sv
// 8-antenna downlink de-interleaver: checks slot cadence (HUNT/SYNC/LOCK) and
// emits one masked 256-bit antenna group per 8 input words while locked.
//   state | meaning
//   HUNT  | waiting for any antenna-0 strobe, nothing captured
//   SYNC  | cadence seen, counting good boundaries, groups discarded
//   LOCK  | cadence trusted, completed groups are emitted
module dl_ant_deint_60m #(
    parameter int          P_LOCK_N   = 2,
    parameter logic [7:0]  P_ANT_MASK = 8'hFF
) (
    input  logic               clk,
    input  logic               asy_rst,
    dl_ant_deint_60m_if.slave  bus
);

    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [2:0]   pos;
    logic [3:0]   good_cnt;
    logic [31:0]  shadow [0:6];
    logic         fram_lat;
    logic         err;
    logic         start;
    logic         cap;
    logic         done;
    logic [255:0] group_word;

    always_ff @(posedge clk or negedge asy_rst) begin
        if (!asy_rst) state <= HUNT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: if (bus.i_ant8_sel) state_nxt = SYNC;
            default: begin
                if (pos == 3'd0) begin
                    if (!bus.i_ant8_sel)
                        state_nxt = HUNT;
                    else if (state == SYNC && (5'(good_cnt) + 5'd1) == 5'(P_LOCK_N))
                        state_nxt = LOCK;
                end else if (bus.i_ant8_sel) begin
                    state_nxt = SYNC;
                end
            end
        endcase
    end

    always_comb begin
        err   = 1'b0;
        start = 1'b0;
        cap   = 1'b0;
        done  = 1'b0;
        bus.o_lock = (state == LOCK);
        case (state)
            HUNT: start = bus.i_ant8_sel;
            default: begin
                if (bus.i_ant8_sel) begin
                    start = 1'b1;
                    err   = (pos != 3'd0);
                end else if (pos == 3'd0) begin
                    err = 1'b1;
                end else begin
                    cap  = 1'b1;
                    done = (pos == 3'd7) && (state == LOCK);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge asy_rst) begin
        if (!asy_rst) begin
            pos      <= 3'd0;
            good_cnt <= 4'd0;
            fram_lat <= 1'b0;
            for (int k = 0; k < 7; k++) shadow[k] <= '0;
        end else if (start) begin
            shadow[0] <= bus.i_data;
            fram_lat  <= bus.i_fram_hd;
            pos       <= 3'd1;
            if (state == HUNT || pos != 3'd0) good_cnt <= 4'd0;
            else if (state == SYNC)           good_cnt <= good_cnt + 4'd1;
        end else if (cap) begin
            if (pos != 3'd7) shadow[pos] <= bus.i_data;
            pos <= pos + 3'd1;
        end
    end

    // Lane 7 is taken straight from the bus so the group appears one cycle after slot 7.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            if (!P_ANT_MASK[k])
                group_word[32*k +: 32] = '0;
            else if (k == 7)
                group_word[32*k +: 32] = bus.i_data;
            else
                group_word[32*k +: 32] = shadow[k];
        end
    end

    always_ff @(posedge clk or negedge asy_rst) begin
        if (!asy_rst) begin
            bus.o_ant_data <= '0;
            bus.o_vld      <= 1'b0;
            bus.o_fram_hd  <= 1'b0;
            bus.o_err_cnt  <= 16'd0;
        end else begin
            bus.o_vld     <= done;
            bus.o_fram_hd <= done & fram_lat;
            if (done) bus.o_ant_data <= group_word;
            if (bus.i_err_clr)
                bus.o_err_cnt <= 16'd0;
            else if (err && bus.o_err_cnt != 16'hFFFF)
                bus.o_err_cnt <= bus.o_err_cnt + 16'd1;
        end
    end

endmodule
